// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a first-word-fall-through byte FIFO.
// Overrun and framing errors are sticky until clr_err.
`timescale 1ns/1ps

module uart_rx_fifo #(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_ADDR_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic                   rd_en,
    input  logic                   clr_err,
    output logic [7:0]             dout,
    output logic                   empty,
    output logic                   full,
    output logic [FIFO_ADDR_W:0]   count,
    output logic                   overrun,
    output logic                   frame_err
);

    localparam int DIV   = SYS_CLK_FREQ / (BAUD_RATE * 16);
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 2 ** FIFO_ADDR_W;

    localparam logic [CW-1:0]          TICK_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]          TICK_ONE  = CW'(1);
    localparam logic [FIFO_ADDR_W-1:0] PTR_ONE   = FIFO_ADDR_W'(1);
    localparam logic [FIFO_ADDR_W:0]   CNT_ONE   = (FIFO_ADDR_W + 1)'(1);
    localparam logic [FIFO_ADDR_W:0]   CNT_FULL  = (FIFO_ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [1:0]    rxSync_q;
    logic          rxPrev_q;
    logic          rxS;
    logic [CW-1:0] tickCnt_q;
    logic [CW-1:0] tickCnt_d;
    logic          tick;

    state_t        state_q;
    logic [3:0]    scnt_q;
    logic [2:0]    bidx_q;
    logic [7:0]    shift_q;
    logic          pushValid_q;
    logic [7:0]    pushByte_q;
    logic          frameErr_q;

    logic [7:0]             mem_q [DEPTH];
    logic [FIFO_ADDR_W-1:0] wrPtr_q;
    logic [FIFO_ADDR_W-1:0] wrPtr_d;
    logic [FIFO_ADDR_W-1:0] rdPtr_q;
    logic [FIFO_ADDR_W-1:0] rdPtr_d;
    logic [FIFO_ADDR_W:0]   count_q;
    logic [FIFO_ADDR_W:0]   count_d;
    logic                   overrun_q;
    logic                   pop;
    logic                   accept;

    assign rxS = rxSync_q[1];

    // Synchroniser presets high so reset looks like an idle line, never a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxSync_q <= 2'b11;
            rxPrev_q <= 1'b1;
        end else begin
            rxSync_q <= {rxSync_q[0], rx};
            rxPrev_q <= rxS;
        end
    end

    assign tick      = (tickCnt_q == TICK_LAST);
    assign tickCnt_d = tick ? '0 : tickCnt_q + TICK_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tickCnt_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_d;
        end
    end

    // Receiver FSM: hands a completed byte to the FIFO as a one-cycle registered push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            scnt_q      <= '0;
            bidx_q      <= '0;
            shift_q     <= '0;
            pushValid_q <= 1'b0;
            pushByte_q  <= '0;
            frameErr_q  <= 1'b0;
        end else begin
            pushValid_q <= 1'b0;
            if (clr_err) begin
                frameErr_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (rxPrev_q && !rxS) begin
                        state_q <= START;
                        scnt_q  <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (scnt_q == 4'd7) begin
                            scnt_q <= '0;
                            bidx_q <= '0;
                            state_q <= rxS ? IDLE : DATA;
                        end else begin
                            scnt_q <= scnt_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (scnt_q == 4'd15) begin
                            scnt_q          <= '0;
                            shift_q[bidx_q] <= rxS;
                            if (bidx_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                bidx_q <= bidx_q + 3'd1;
                            end
                        end else begin
                            scnt_q <= scnt_q + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (scnt_q == 4'd15) begin
                            scnt_q  <= '0;
                            state_q <= IDLE;
                            if (rxS) begin
                                pushValid_q <= 1'b1;
                                pushByte_q  <= shift_q;
                            end else begin
                                frameErr_q <= 1'b1;
                            end
                        end else begin
                            scnt_q <= scnt_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign pop    = rd_en && (count_q != '0);
    assign accept = pushValid_q && ((count_q != CNT_FULL) || pop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (accept) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                mem_q[wrPtr_q] <= pushByte_q;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (pushValid_q && !accept) begin
                overrun_q <= 1'b1;
            end else if (clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign dout      = mem_q[rdPtr_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven on rx, received bytes tracked through
// an expected-byte queue and compared as the FIFO is drained.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int SYS   = 3200;
    localparam int BAUD  = 100;
    localparam int AW    = 3;
    localparam int BIT   = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          rd_en;
    logic          clr_err;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          frame_err;

    logic [7:0] expQ [$];
    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        logic       expPush;
        logic       expFrameErr;
        logic       drainAfter;
    } vec_t;

    vec_t vecs [5];

    uart_rx_fifo #(
        .SYS_CLK_FREQ(SYS),
        .BAUD_RATE(BAUD),
        .FIFO_ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rd_en(rd_en),
        .clr_err(clr_err),
        .dout(dout),
        .empty(empty),
        .full(full),
        .count(count),
        .overrun(overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sends one full 8N1 frame; optionally pops at cycle popAt and reports the first cycle count moved.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input int popAt,
                                 output int changeAt);
        logic [9:0]  bits;
        logic [AW:0] prev;
        bits     = {stopBit, b, 1'b0};
        prev     = count;
        changeAt = -1;
        for (int cyc = 0; cyc < 10 * BIT; cyc++) begin
            rx    = bits[cyc / BIT];
            rd_en = (cyc == popAt);
            if (cyc == popAt && expQ.size() > 0) begin
                checkOutput("popDuringRx", dout, expQ.pop_front());
            end
            cycles(1);
            if (changeAt < 0 && count !== prev) begin
                changeAt = cyc;
            end
        end
        rd_en = 1'b0;
        rx    = 1'b1;
    endtask

    task automatic drainAll();
        int w;
        while (expQ.size() > 0) begin
            w = 0;
            while (empty && w < 20 * BIT) begin
                cycles(1);
                w++;
            end
            checkOutput("drainReady", empty, 1'b0);
            checkOutput("drainDout", dout, expQ.pop_front());
            rd_en = 1'b1;
            cycles(1);
            rd_en = 1'b0;
        end
        checkOutput("emptyAfterDrain", empty, 1'b1);
    endtask

    task automatic pulseClrErr();
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ch;
        int ch8;
        int ch9;
        logic [7:0] partial;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b1};

        rst     = 1'b1;
        rx      = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        cycles(3);
        checkOutput("resetEmpty", empty, 1'b1);
        checkOutput("resetFull", full, 1'b0);
        checkOutput("resetCount", count, 0);
        checkOutput("resetDout", dout, 8'h00);
        checkOutput("resetOverrun", overrun, 1'b0);
        checkOutput("resetFrameErr", frame_err, 1'b0);
        rst = 1'b0;
        cycles(5);

        // Single byte, back-to-back bytes, and a frame with a bad stop bit.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stopBit, -1, ch);
            if (vecs[i].expPush) begin
                expQ.push_back(vecs[i].data);
            end
            checkOutput("countAfterFrame", count, expQ.size());
            checkOutput("frameErrAfterFrame", frame_err, vecs[i].expFrameErr);
            if (vecs[i].expFrameErr) begin
                pulseClrErr();
                checkOutput("frameErrCleared", frame_err, 1'b0);
            end
            if (vecs[i].drainAfter) begin
                drainAll();
            end
        end
        checkOutput("noOverrunSeq", overrun, 1'b0);

        // Short low glitch must be rejected at the start-bit midpoint.
        rx = 1'b0;
        cycles(4);
        rx = 1'b1;
        cycles(3 * BIT);
        checkOutput("glitchCount", count, 0);
        checkOutput("glitchEmpty", empty, 1'b1);
        checkOutput("glitchFrameErr", frame_err, 1'b0);

        // Nine bytes into an eight-deep FIFO with no reads.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(8'h10 + 8'(i), 1'b1, -1, ch);
            if (i < DEPTH) begin
                expQ.push_back(8'h10 + 8'(i));
            end
            if (i == DEPTH - 1) begin
                checkOutput("fullAt8", full, 1'b1);
                checkOutput("overrunBefore9", overrun, 1'b0);
            end
        end
        checkOutput("fullAfter9", full, 1'b1);
        checkOutput("countAfter9", count, DEPTH);
        checkOutput("overrunAfter9", overrun, 1'b1);
        drainAll();
        pulseClrErr();
        checkOutput("overrunCleared", overrun, 1'b0);

        // Same again, but pop on exactly the cycle the ninth byte is pushed.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(8'h20 + 8'(i), 1'b1, -1, ch8);
            expQ.push_back(8'h20 + 8'(i));
        end
        checkOutput("pushSeen", (ch8 >= 0), 1'b1);
        applyStimulus(8'h28, 1'b1, ch8, ch9);
        expQ.push_back(8'h28);
        checkOutput("simulOverrun", overrun, 1'b0);
        checkOutput("simulCount", count, DEPTH);
        checkOutput("simulFull", full, 1'b1);
        drainAll();

        // Reset in the middle of a frame discards both the partial byte and FIFO contents.
        applyStimulus(8'h77, 1'b1, -1, ch);
        checkOutput("preResetCount", count, 1);
        partial = 8'h81;
        rx = 1'b0;
        cycles(BIT);
        for (int k = 0; k < 4; k++) begin
            rx = partial[k];
            cycles(BIT);
        end
        rst = 1'b1;
        rx  = 1'b1;
        cycles(2);
        checkOutput("midResetCount", count, 0);
        checkOutput("midResetEmpty", empty, 1'b1);
        checkOutput("midResetDout", dout, 8'h00);
        checkOutput("midResetFrameErr", frame_err, 1'b0);
        expQ.delete();
        rst = 1'b0;
        cycles(BIT);
        applyStimulus(8'h42, 1'b1, -1, ch);
        expQ.push_back(8'h42);
        checkOutput("postResetCount", count, 1);
        drainAll();
        checkOutput("postResetFrameErr", frame_err, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
